// File: rtl/banco_ctrl.sv
// banco_ctrl: write-port controller for banco_registro.
// Arbitrates the bank's single write port between requesters A and B
// (req/ack handshake, round-robin on ties) and runs a bulk-clear sweep
// that writes zero to registers 0..NUM_REGS-1. Every output is registered.
module banco_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              ack_b,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              bank_we,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [DATA_W-1:0] bank_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // Final address of the sweep; with NUM_REGS = 2**ADDR_W this is all-ones,
  // so the counter stops there instead of wrapping.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_next;
  logic              last_b, last_b_next;   // 1: B received the most recent grant
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_next;
  logic              bank_we_next;
  logic [ADDR_W-1:0] bank_addr_next;
  logic [DATA_W-1:0] bank_data_next;
  logic              ack_a_next, ack_b_next;
  logic              clr_busy_next, clr_done_next;
  logic              grant_a, grant_b;

  // Round-robin arbitration: a lone request wins; on a tie the requester
  // that was not granted last wins.
  always_comb begin
    grant_a = req_a && (!req_b || last_b);
    grant_b = req_b && (!req_a || !last_b);
  end

  // Next-state and next-output logic; pulses default low, bank bus holds.
  always_comb begin
    state_next     = state;
    last_b_next    = last_b;
    clr_cnt_next   = clr_cnt;
    bank_we_next   = 1'b0;
    bank_addr_next = bank_addr;
    bank_data_next = bank_data;
    ack_a_next     = 1'b0;
    ack_b_next     = 1'b0;
    clr_busy_next  = 1'b0;
    clr_done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_start) begin
          // Clear has priority; any pending request simply keeps waiting.
          state_next     = CLEAR;
          clr_cnt_next   = '0;
          clr_busy_next  = 1'b1;
          bank_we_next   = 1'b1;
          bank_addr_next = '0;
          bank_data_next = '0;
        end else if (grant_a) begin
          state_next     = WRITE;
          bank_we_next   = 1'b1;
          bank_addr_next = addr_a;
          bank_data_next = data_a;
          ack_a_next     = 1'b1;
          last_b_next    = 1'b0;
        end else if (grant_b) begin
          state_next     = WRITE;
          bank_we_next   = 1'b1;
          bank_addr_next = addr_b;
          bank_data_next = data_b;
          ack_b_next     = 1'b1;
          last_b_next    = 1'b1;
        end
      end
      WRITE: begin
        // Single-cycle write; the requester drops req before IDLE looks again.
        state_next = IDLE;
      end
      CLEAR: begin
        if (clr_cnt == LAST_ADDR) begin
          state_next    = IDLE;
          clr_done_next = 1'b1;
        end else begin
          clr_cnt_next   = clr_cnt + 1'b1;
          clr_busy_next  = 1'b1;
          bank_we_next   = 1'b1;
          bank_addr_next = clr_cnt + 1'b1;
          bank_data_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any write or sweep at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      clr_cnt   <= '0;
      bank_we   <= 1'b0;
      bank_addr <= '0;
      bank_data <= '0;
      ack_a     <= 1'b0;
      ack_b     <= 1'b0;
      clr_busy  <= 1'b0;
      clr_done  <= 1'b0;
    end else begin
      state     <= state_next;
      last_b    <= last_b_next;
      clr_cnt   <= clr_cnt_next;
      bank_we   <= bank_we_next;
      bank_addr <= bank_addr_next;
      bank_data <= bank_data_next;
      ack_a     <= ack_a_next;
      ack_b     <= ack_b_next;
      clr_busy  <= clr_busy_next;
      clr_done  <= clr_done_next;
    end
  end

endmodule

// File: tb/tb_banco_ctrl.sv
// Testbench for banco_ctrl: directed steps plus a randomized phase, checked
// against a transaction-level model (round-robin winner, expected bank image).
module tb_banco_ctrl;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst;

  // Main instance (NUM_REGS = 4)
  logic          req_a, req_b, clr_start;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] data_a, data_b;
  logic          ack_a, ack_b, clr_busy, clr_done, bank_we;
  logic [AW-1:0] bank_addr;
  logic [DW-1:0] bank_data;

  // NUM_REGS = 1 instance
  logic          clr_start_one;
  logic          ack_a_one, ack_b_one, clr_busy_one, clr_done_one, bank_we_one;
  logic [AW-1:0] bank_addr_one;
  logic [DW-1:0] bank_data_one;

  // NUM_REGS = 2**ADDR_W instance (ADDR_W = 2)
  logic          clr_start_full;
  logic [1:0]    zero_addr2;
  logic          ack_a_full, ack_b_full, clr_busy_full, clr_done_full, bank_we_full;
  logic [1:0]    bank_addr_full;
  logic [DW-1:0] bank_data_full;

  logic          zero_bit;
  logic [AW-1:0] zero_addr;
  logic [DW-1:0] zero_data;

  int checks = 0;
  int errors = 0;

  // Stand-in for the register bank and the expected bank image
  logic [DW-1:0] bank_mem [0:255];
  logic [DW-1:0] exp_mem  [0:255];
  bit            exp_valid[0:255];
  bit            exp_last_b;

  always #5 clk = ~clk;

  banco_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .ack_b(ack_b),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .bank_we(bank_we), .bank_addr(bank_addr), .bank_data(bank_data)
  );

  banco_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(1)) dut_one (
    .clk(clk), .rst(rst),
    .req_a(zero_bit), .addr_a(zero_addr), .data_a(zero_data), .ack_a(ack_a_one),
    .req_b(zero_bit), .addr_b(zero_addr), .data_b(zero_data), .ack_b(ack_b_one),
    .clr_start(clr_start_one), .clr_busy(clr_busy_one), .clr_done(clr_done_one),
    .bank_we(bank_we_one), .bank_addr(bank_addr_one), .bank_data(bank_data_one)
  );

  banco_ctrl #(.DATA_W(DW), .ADDR_W(2), .NUM_REGS(4)) dut_full (
    .clk(clk), .rst(rst),
    .req_a(zero_bit), .addr_a(zero_addr2), .data_a(zero_data), .ack_a(ack_a_full),
    .req_b(zero_bit), .addr_b(zero_addr2), .data_b(zero_data), .ack_b(ack_b_full),
    .clr_start(clr_start_full), .clr_busy(clr_busy_full), .clr_done(clr_done_full),
    .bank_we(bank_we_full), .bank_addr(bank_addr_full), .bank_data(bank_data_full)
  );

  // Bank write port of the main instance
  always @(posedge clk) begin
    if (bank_we === 1'b1) bank_mem[bank_addr] <= bank_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [7:0] a,
                         input logic [7:0] d, input logic aa, input logic ab,
                         input logic busy, input logic done);
    chk({tag, ".we"},   32'(bank_we),   32'(we));
    chk({tag, ".addr"}, 32'(bank_addr), 32'(a));
    chk({tag, ".data"}, 32'(bank_data), 32'(d));
    chk({tag, ".ack_a"}, 32'(ack_a),    32'(aa));
    chk({tag, ".ack_b"}, 32'(ack_b),    32'(ab));
    chk({tag, ".busy"}, 32'(clr_busy),  32'(busy));
    chk({tag, ".done"}, 32'(clr_done),  32'(done));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic note_write(input logic [7:0] a, input logic [7:0] d);
    exp_mem[a]   = d;
    exp_valid[a] = 1'b1;
  endtask

  task automatic note_clear();
    for (int i = 0; i < NR; i++) note_write(8'(i), 8'h00);
  endtask

  initial begin
    bit pa, pb, win_b;
    logic [7:0] wa, wd;

    rst = 1'b1;
    req_a = 0; req_b = 0; clr_start = 0;
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
    clr_start_one = 0; clr_start_full = 0;
    zero_bit = 0; zero_addr = '0; zero_data = '0; zero_addr2 = '0;
    exp_last_b = 1'b1;
    for (int i = 0; i < 256; i++) begin
      exp_mem[i] = '0;
      exp_valid[i] = 1'b0;
    end

    // 1. Reset while clock runs
    #5 rst = 1'b0;
    #2;
    chk_out("reset", 0, 8'h00, 8'h00, 0, 0, 0, 0);
    chk("reset.one_we", 32'(bank_we_one), 32'd0);
    chk("reset.full_we", 32'(bank_we_full), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    tick();
    tick();
    chk_out("idle", 0, 8'h00, 8'h00, 0, 0, 0, 0);

    // 2. Single write from A
    req_a = 1; addr_a = 8'h01; data_a = 8'h68;
    tick();
    chk_out("wr1", 1, 8'h01, 8'h68, 1, 0, 0, 0);
    exp_last_b = 1'b0;
    tick();
    chk_out("wr1_end", 0, 8'h01, 8'h68, 0, 0, 0, 0);
    req_a = 0;
    note_write(8'h01, 8'h68);
    chk("wr1.mem1", 32'(bank_mem[1]), 32'h68);

    // 3. Contention: both held for 3 transactions each
    req_a = 1; addr_a = 8'h02; data_a = 8'h11;
    req_b = 1; addr_b = 8'h03; data_b = 8'h22;
    for (int k = 0; k < 6; k++) begin
      win_b = !exp_last_b;
      tick();
      if (win_b) chk_out($sformatf("rr%0d", k), 1, 8'h03, 8'h22, 0, 1, 0, 0);
      else       chk_out($sformatf("rr%0d", k), 1, 8'h02, 8'h11, 1, 0, 0, 0);
      exp_last_b = win_b;
      tick();
      chk($sformatf("rr%0d.gap_we", k), 32'(bank_we), 32'd0);
      chk($sformatf("rr%0d.gap_ack", k), 32'({ack_a, ack_b}), 32'd0);
    end
    req_a = 0; req_b = 0;
    note_write(8'h02, 8'h11);
    note_write(8'h03, 8'h22);
    chk("rr.mem2", 32'(bank_mem[2]), 32'h11);
    chk("rr.mem3", 32'(bank_mem[3]), 32'h22);

    // 4. Preload addr 2 = 0x55, with clr_start during WRITE being ignored
    req_a = 1; addr_a = 8'h02; data_a = 8'h55;
    tick();
    chk_out("pre", 1, 8'h02, 8'h55, 1, 0, 0, 0);
    exp_last_b = 1'b0;
    clr_start = 1;
    tick();
    clr_start = 0; req_a = 0;
    chk_out("pre_end", 0, 8'h02, 8'h55, 0, 0, 0, 0);
    tick();
    chk_out("wr_clr_ignored", 0, 8'h02, 8'h55, 0, 0, 0, 0);
    note_write(8'h02, 8'h55);
    chk("pre.mem2", 32'(bank_mem[2]), 32'h55);

    // Clear sweep of 4 registers; clr_start during CLEAR is ignored
    clr_start = 1;
    tick();
    clr_start = 0;
    chk_out("clr0", 1, 8'h00, 8'h00, 0, 0, 1, 0);
    for (int i = 1; i < NR; i++) begin
      if (i == 1) clr_start = 1;
      tick();
      if (i == 2) clr_start = 0;
      chk_out($sformatf("clr%0d", i), 1, 8'(i), 8'h00, 0, 0, 1, 0);
    end
    tick();
    chk_out("clr_done", 0, 8'(NR - 1), 8'h00, 0, 0, 0, 1);
    tick();
    chk_out("clr_after", 0, 8'(NR - 1), 8'h00, 0, 0, 0, 0);
    note_clear();
    chk("clr.mem2", 32'(bank_mem[2]), 32'h00);

    // 5. Collision: clear wins, B waits and is granted after clr_done
    clr_start = 1; req_b = 1; addr_b = 8'h01; data_b = 8'h77;
    tick();
    clr_start = 0;
    chk_out("col0", 1, 8'h00, 8'h00, 0, 0, 1, 0);
    for (int i = 1; i < NR; i++) begin
      tick();
      chk_out($sformatf("col%0d", i), 1, 8'(i), 8'h00, 0, 0, 1, 0);
    end
    tick();
    chk_out("col_done", 0, 8'(NR - 1), 8'h00, 0, 0, 0, 1);
    tick();
    chk_out("col_grant", 1, 8'h01, 8'h77, 0, 1, 0, 0);
    exp_last_b = 1'b1;
    tick();
    req_b = 0;
    chk("col_end.we", 32'(bank_we), 32'd0);
    note_clear();
    note_write(8'h01, 8'h77);
    chk("col.mem1", 32'(bank_mem[1]), 32'h77);

    // 6. Reset during the 2nd sweep cycle
    clr_start = 1;
    tick();
    clr_start = 0;
    tick();
    chk_out("rmid_pre", 1, 8'h01, 8'h00, 0, 0, 1, 0);
    #2 rst = 1'b0;
    #1;
    chk_out("rmid", 0, 8'h00, 8'h00, 0, 0, 0, 0);
    exp_last_b = 1'b1;
    tick();
    chk("rmid.mem1_kept", 32'(bank_mem[1]), 32'h77);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("rmid_idle%0d", i), 0, 8'h00, 8'h00, 0, 0, 0, 0);
    end
    clr_start = 1;
    tick();
    clr_start = 0;
    chk_out("restart0", 1, 8'h00, 8'h00, 0, 0, 1, 0);
    for (int i = 1; i < NR; i++) begin
      tick();
      chk_out($sformatf("restart%0d", i), 1, 8'(i), 8'h00, 0, 0, 1, 0);
    end
    tick();
    chk_out("restart_done", 0, 8'(NR - 1), 8'h00, 0, 0, 0, 1);
    tick();
    note_clear();

    // Randomized requests against the round-robin model
    pa = 0; pb = 0;
    for (int n = 0; n < 60; n++) begin
      if (!pa && ($urandom_range(0, 3) != 0)) begin
        pa = 1; req_a = 1;
        addr_a = 8'($urandom_range(0, 255)); data_a = 8'($urandom_range(0, 255));
      end
      if (!pb && ($urandom_range(0, 3) != 0)) begin
        pb = 1; req_b = 1;
        addr_b = 8'($urandom_range(0, 255)); data_b = 8'($urandom_range(0, 255));
      end
      if (!pa && !pb) begin
        tick();
        chk($sformatf("rnd%0d.idle_we", n), 32'(bank_we), 32'd0);
        continue;
      end
      win_b = pb && (!pa || !exp_last_b);
      wa = win_b ? addr_b : addr_a;
      wd = win_b ? data_b : data_a;
      tick();
      chk($sformatf("rnd%0d.ack", n), 32'({ack_a, ack_b}), win_b ? 32'd1 : 32'd2);
      chk($sformatf("rnd%0d.we", n), 32'(bank_we), 32'd1);
      chk($sformatf("rnd%0d.addr", n), 32'(bank_addr), 32'(wa));
      chk($sformatf("rnd%0d.data", n), 32'(bank_data), 32'(wd));
      exp_last_b = win_b;
      note_write(wa, wd);
      tick();
      chk($sformatf("rnd%0d.gap", n), 32'({bank_we, ack_a, ack_b}), 32'd0);
      if (win_b) begin pb = 0; req_b = 0; end
      else       begin pa = 0; req_a = 0; end
    end
    req_a = 0; req_b = 0;
    tick();
    for (int i = 0; i < 256; i++) begin
      if (exp_valid[i]) chk($sformatf("mem[%0d]", i), 32'(bank_mem[i]), 32'(exp_mem[i]));
    end

    // NUM_REGS = 1 and NUM_REGS = 2**ADDR_W sweeps
    clr_start_one = 1; clr_start_full = 1;
    tick();
    clr_start_one = 0; clr_start_full = 0;
    chk("one0", 32'({bank_we_one, clr_busy_one, clr_done_one}), 32'b110);
    chk("one0.addr", 32'(bank_addr_one), 32'd0);
    chk("full0", 32'({bank_we_full, clr_busy_full, bank_addr_full}), 32'b1100);
    tick();
    chk("one_done", 32'({bank_we_one, clr_busy_one, clr_done_one}), 32'b001);
    chk("full1", 32'({bank_we_full, clr_busy_full, bank_addr_full}), 32'b1101);
    tick();
    chk("one_after", 32'({bank_we_one, clr_busy_one, clr_done_one, ack_a_one, ack_b_one}), 32'd0);
    chk("full2", 32'({bank_we_full, clr_busy_full, bank_addr_full}), 32'b1110);
    tick();
    chk("full3", 32'({bank_we_full, clr_busy_full, bank_addr_full}), 32'b1111);
    chk("full3.data", 32'(bank_data_full), 32'd0);
    tick();
    chk("full_done", 32'({bank_we_full, clr_busy_full, clr_done_full, bank_addr_full}), 32'b00111);
    tick();
    chk("full_after", 32'({bank_we_full, clr_busy_full, clr_done_full, ack_a_full, ack_b_full}), 32'd0);
    chk("one_data", 32'(bank_data_one), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
